// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg -- shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM encoding (S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_TRAP)
//   INST_BYTES    : size of one instruction word in bytes
//   NOP_INST      : canonical NOP (addi x0, x0, 0) shown in IF/ID after reset
//   next_pc()     : sequential PC increment, wraps modulo 2^64
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_TRAP  = 3'd4
  } fetch_state_t;

  function automatic logic [63:0] next_pc(input logic [63:0] pc);
    return pc + 64'(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid -- one-entry skid buffer that parks a returned instruction while
// the IF/ID register is still occupied by an entry decode has not consumed.
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture load_word/load_pc, mark entry valid
//   unload        : entry moved into IF/ID, mark empty
//   clear         : flush (redirect); wins over load and unload
//   valid/word/pc : held entry
// -----------------------------------------------------------------------------
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] load_word,
  input  logic [63:0] load_pc,
  output logic        valid,
  output logic [31:0] word,
  output logic [63:0] pc
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

  // NOTE: payload registers are deliberately not reset; they are only read
  // while valid is set, so resetting them would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (load) begin
      word <= load_word;
      pc   <= load_pc;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage with a single outstanding memory
// request, an IF/ID pipeline register and a one-entry skid buffer.
//   clk, rst                        : clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr : request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data   : response channel (one word per request)
//   redirect_valid, redirect_pc     : control-flow change from downstream
//   id_ready                        : decode consumes the IF/ID entry
//   inst_valid, inst_code, inst_pc  : IF/ID register
//   fetch_misalign                  : misaligned redirect target trap flag
// Build option: define MISALIGN_TRAP_EN to trap on redirect targets whose low
// two bits are non-zero; otherwise those bits are forced to zero.
// -----------------------------------------------------------------------------
module inst_fetch
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [63:0] inst_pc,
  output logic        fetch_misalign
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q;
  logic [63:0]  redirect_target;
  logic         redirect_misaligned;

  logic         skid_valid;
  logic [31:0]  skid_word;
  logic [63:0]  skid_pc;

`ifdef MISALIGN_TRAP_EN
  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_target     = redirect_pc & ~64'h3;
  assign redirect_misaligned = 1'b0;
`endif

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = pc_q;

  // A response is only meaningful in S_WAIT; in S_DRAIN it is swallowed and
  // everywhere else it is ignored.
  logic rsp_take, ifid_free, load_rsp, load_skid, unload_skid, still_pending;
  assign rsp_take    = (state_q == S_WAIT) && imem_rsp_valid;
  assign ifid_free   = !inst_valid || id_ready;
  assign load_rsp    = !redirect_valid && rsp_take && ifid_free;
  assign load_skid   = !redirect_valid && rsp_take && !ifid_free;
  assign unload_skid = !redirect_valid && (state_q == S_HOLD) && skid_valid && id_ready;

  // A request is still in flight after this edge if it was accepted now, or
  // was already outstanding and its response has not arrived this cycle.
  assign still_pending = ((state_q == S_REQ) && imem_req_ready) ||
                         (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rsp_valid);

  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      if (redirect_misaligned)  state_d = S_TRAP;
      else if (still_pending)   state_d = S_DRAIN;
      else                      state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ:   if (imem_req_ready) state_d = S_WAIT;
        S_WAIT:  if (imem_rsp_valid) state_d = ifid_free ? S_REQ : S_HOLD;
        S_HOLD:  if (id_ready)       state_d = S_REQ;
        S_DRAIN: if (imem_rsp_valid) state_d = S_REQ;
        S_TRAP:                      state_d = S_TRAP;
        default:                     state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_valid <= 1'b0;
      inst_code  <= NOP_INST;
      inst_pc    <= '0;
    end else begin
      state_q <= state_d;

      if (redirect_valid)  pc_q <= redirect_target;
      else if (rsp_take)   pc_q <= next_pc(pc_q);

      if (redirect_valid) begin
        inst_valid <= 1'b0;
      end else if (load_rsp) begin
        inst_valid <= 1'b1;
        inst_code  <= imem_rsp_data;
        inst_pc    <= pc_q;
      end else if (unload_skid) begin
        inst_valid <= 1'b1;
        inst_code  <= skid_word;
        inst_pc    <= skid_pc;
      end else if (id_ready) begin
        inst_valid <= 1'b0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst)                 misalign_q <= 1'b0;
    else if (redirect_valid) misalign_q <= redirect_misaligned;
  end
  assign fetch_misalign = misalign_q;
`else
  assign fetch_misalign = 1'b0;
`endif

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (load_skid),
    .unload    (unload_skid),
    .clear     (redirect_valid),
    .load_word (imem_rsp_data),
    .load_pc   (pc_q),
    .valid     (skid_valid),
    .word      (skid_word),
    .pc        (skid_pc)
  );

endmodule
